// File: rtl/exc_seq.sv
// exc_seq: exception/interrupt entry-and-return sequencer for the multi-cycle
// MIPS core. It arbitrates ERET / SYSCALL / interrupt at instruction
// boundaries and drives the CP0 strobes and the PC-load path in a fixed
// cycle sequence, holding fetch while it runs.
//
// Configuration macro: EXC_SYSCALL_EN
//   defined   - syscall is arbitrated (exc_code 8)
//   undefined - syscall input is ignored, exc_code is always 0
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   intreq      - masked interrupt request (level, sampled at boundaries)
//   insn_done   - last cycle of an instruction (the decision point)
//   eret        - decoded ERET, valid with insn_done
//   syscall     - decoded SYSCALL, valid with insn_done
//   next_pc     - next sequential word address, valid with insn_done
//   epc         - current EPC from CP0
//   hold        - fetch/PC stall while sequencing
//   epc_we      - EPC write strobe, pc_save is the data
//   exlset      - one-cycle pulse setting SR.EXL
//   exlclr      - one-cycle pulse clearing SR.EXL
//   pc_load     - force PC to pc_target
//   pc_target   - handler vector or EPC
//   exc_code    - cause of the last entry (0 = Int, 8 = Sys)
//   exc_count   - number of entries taken, modulo 256
module exc_seq #(
  parameter logic [29:0] VECTOR = 30'h0000_1060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intreq,
  input  logic        insn_done,
  input  logic        eret,
  input  logic        syscall,
  input  logic [29:0] next_pc,
  input  logic [29:0] epc,
  output logic        hold,
  output logic        epc_we,
  output logic [29:0] pc_save,
  output logic        exlset,
  output logic        exlclr,
  output logic        pc_load,
  output logic [29:0] pc_target,
  output logic [4:0]  exc_code,
  output logic [7:0]  exc_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    ENTER = 2'd2,
    RET   = 2'd3
  } state_t;

  state_t state;
  state_t nstate;

  logic sys_req;

`ifdef EXC_SYSCALL_EN
  assign sys_req = syscall;
`else
  // Port kept for a uniform interface; never arbitrated in this build.
  assign sys_req = 1'b0 & syscall;
`endif

  logic boundary;
  assign boundary = (state == IDLE) && insn_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic; priority eret > syscall > intreq
  always_comb begin
    nstate = state;
    case (state)
      IDLE: begin
        if (insn_done) begin
          if (eret) begin
            nstate = RET;
          end else if (sys_req || intreq) begin
            nstate = SAVE;
          end
        end
      end
      SAVE:    nstate = ENTER;
      ENTER:   nstate = IDLE;
      RET:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Output logic: strobe values decoded from the state being entered, then
  // registered so every strobe is a clean flop output aligned with the state.
  logic hold_n;
  logic epc_we_n;
  logic exlset_n;
  logic exlclr_n;
  logic pc_load_n;

  always_comb begin
    hold_n    = 1'b0;
    epc_we_n  = 1'b0;
    exlset_n  = 1'b0;
    exlclr_n  = 1'b0;
    pc_load_n = 1'b0;
    case (nstate)
      SAVE: begin
        hold_n   = 1'b1;
        epc_we_n = 1'b1;
      end
      ENTER: begin
        hold_n    = 1'b1;
        exlset_n  = 1'b1;
        pc_load_n = 1'b1;
      end
      RET: begin
        hold_n    = 1'b1;
        exlclr_n  = 1'b1;
        pc_load_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= 1'b0;
      epc_we  <= 1'b0;
      exlset  <= 1'b0;
      exlclr  <= 1'b0;
      pc_load <= 1'b0;
    end else begin
      hold    <= hold_n;
      epc_we  <= epc_we_n;
      exlset  <= exlset_n;
      exlclr  <= exlclr_n;
      pc_load <= pc_load_n;
    end
  end

  // Entry bookkeeping: saved PC and cause are latched at the boundary and
  // held until the next entry; the target is captured on entry to ENTER/RET.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_save   <= '0;
      exc_code  <= '0;
      pc_target <= '0;
      exc_count <= '0;
    end else begin
      if (boundary && !eret && (sys_req || intreq)) begin
        pc_save  <= next_pc;
        exc_code <= sys_req ? 5'd8 : 5'd0;
      end
      if (nstate == ENTER) begin
        pc_target <= VECTOR;
        exc_count <= exc_count + 8'd1;
      end else if (nstate == RET) begin
        pc_target <= epc;
      end
    end
  end

endmodule

// File: tb/tb_exc_seq.sv
module tb_exc_seq;

  localparam logic [29:0] VEC = 30'h0000_1060;
`ifdef EXC_SYSCALL_EN
  localparam bit SYS_EN = 1'b1;
`else
  localparam bit SYS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        intreq, insn_done, eret, syscall;
  logic [29:0] next_pc, epc;
  logic        hold, epc_we, exlset, exlclr, pc_load;
  logic [29:0] pc_save, pc_target;
  logic [4:0]  exc_code;
  logic [7:0]  exc_count;

  exc_seq #(.VECTOR(VEC)) dut (
    .clk(clk), .rst(rst), .intreq(intreq), .insn_done(insn_done),
    .eret(eret), .syscall(syscall), .next_pc(next_pc), .epc(epc),
    .hold(hold), .epc_we(epc_we), .pc_save(pc_save), .exlset(exlset),
    .exlclr(exlclr), .pc_load(pc_load), .pc_target(pc_target),
    .exc_code(exc_code), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a timeline of expected per-cycle behaviour. A decision
  // at a boundary appends the whole entry/return sequence to a queue that is
  // consumed one element per clock.
  typedef struct {
    bit          hold;
    bit          epc_we;
    bit          exlset;
    bit          exlclr;
    bit          pc_load;
    bit          ld_tgt;
    bit          inc;
    logic [29:0] tgt;
  } step_t;

  step_t       q[$];
  step_t       cur;
  logic [29:0] m_save = '0;
  logic [29:0] m_target = '0;
  logic [4:0]  m_code = '0;
  logic [7:0]  m_count = '0;

  function automatic step_t mk(bit h, bit we, bit st, bit cl, bit ld, bit lt, bit inc,
                               logic [29:0] t);
    step_t s;
    s.hold = h; s.epc_we = we; s.exlset = st; s.exlclr = cl; s.pc_load = ld;
    s.ld_tgt = lt; s.inc = inc; s.tgt = t;
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = mk(0, 0, 0, 0, 0, 0, 0, '0);
      m_save = '0; m_target = '0; m_code = '0; m_count = '0;
    end else begin
      if (!cur.hold && insn_done) begin
        if (eret) begin
          q.push_back(mk(1, 0, 0, 1, 1, 1, 0, epc));
        end else if ((SYS_EN && syscall) || intreq) begin
          m_save = next_pc;
          m_code = (SYS_EN && syscall) ? 5'd8 : 5'd0;
          q.push_back(mk(1, 1, 0, 0, 0, 0, 0, '0));
          q.push_back(mk(1, 0, 1, 0, 1, 1, 1, VEC));
        end
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(0, 0, 0, 0, 0, 0, 0, '0);
      if (cur.ld_tgt) m_target = cur.tgt;
      if (cur.inc) m_count = m_count + 8'd1;
    end
  end

  task automatic compare();
    chk("hold", {31'd0, hold}, {31'd0, cur.hold});
    chk("epc_we", {31'd0, epc_we}, {31'd0, cur.epc_we});
    chk("exlset", {31'd0, exlset}, {31'd0, cur.exlset});
    chk("exlclr", {31'd0, exlclr}, {31'd0, cur.exlclr});
    chk("pc_load", {31'd0, pc_load}, {31'd0, cur.pc_load});
    chk("pc_target", {2'd0, pc_target}, {2'd0, m_target});
    chk("pc_save", {2'd0, pc_save}, {2'd0, m_save});
    chk("exc_code", {27'd0, exc_code}, {27'd0, m_code});
    chk("exc_count", {24'd0, exc_count}, {24'd0, m_count});
    chk("we_set_excl", {31'd0, epc_we & exlset}, 32'd0);
  endtask

  // Advance one clock; inputs change at negedge, outputs checked at negedge.
  task automatic step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    intreq = 0; insn_done = 0; eret = 0; syscall = 0;
  endtask

  initial begin
    rst = 1; set_idle(); next_pc = '0; epc = '0;
    step(); step();
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_count", {24'd0, exc_count}, 32'd0);
    rst = 0;
    step();

    // Interrupt entry
    intreq = 1; insn_done = 1; next_pc = 30'h100;
    step();
    set_idle();
    chk("int_we_t1", {31'd0, epc_we}, 32'd1);
    chk("int_save_t1", {2'd0, pc_save}, 32'h100);
    step();
    chk("int_set_t2", {31'd0, exlset}, 32'd1);
    chk("int_tgt_t2", {2'd0, pc_target}, 32'h1060);
    chk("int_cnt_t2", {24'd0, exc_count}, 32'd1);
    chk("int_code", {27'd0, exc_code}, 32'd0);
    step();
    chk("int_hold_t3", {31'd0, hold}, 32'd0);

    // ERET
    epc = 30'h100; eret = 1; insn_done = 1;
    step();
    set_idle();
    chk("eret_clr_t1", {31'd0, exlclr}, 32'd1);
    chk("eret_tgt_t1", {2'd0, pc_target}, 32'h100);
    step();
    chk("eret_hold_t2", {31'd0, hold}, 32'd0);

    // Priority: all requests at once
    eret = 1; syscall = 1; intreq = 1; insn_done = 1; epc = 30'h3ab; next_pc = 30'h55;
    step();
    set_idle();
    chk("prio_clr", {31'd0, exlclr}, 32'd1);
    chk("prio_we", {31'd0, epc_we}, 32'd0);
    step();
    chk("prio_we2", {31'd0, epc_we}, 32'd0);

    // Syscall
    syscall = 1; insn_done = 1; next_pc = 30'h204;
    step();
    set_idle();
    chk("sys_hold", {31'd0, hold}, {31'd0, SYS_EN});
    chk("sys_save", {2'd0, pc_save}, SYS_EN ? 32'h204 : 32'h100);
    chk("sys_code", {27'd0, exc_code}, SYS_EN ? 32'd8 : 32'd0);
    step(); step();

    // Reset during SAVE
    intreq = 1; insn_done = 1; next_pc = 30'h77;
    step();
    set_idle();
    chk("mid_we", {31'd0, epc_we}, 32'd1);
    rst = 1;
    #1;
    chk("mid_we_drop", {31'd0, epc_we}, 32'd0);
    chk("mid_hold_drop", {31'd0, hold}, 32'd0);
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_noset", {31'd0, exlset}, 32'd0);
    end

    // 256 entries wrap the counter
    for (int i = 0; i < 256; i++) begin
      intreq = 1; insn_done = 1; next_pc = 30'(i);
      step();
      set_idle();
      step(); step();
    end
    chk("wrap_cnt", {24'd0, exc_count}, 32'd0);

    // intreq only while hold is high
    eret = 1; insn_done = 1; epc = 30'h44;
    step();
    eret = 0; intreq = 1; insn_done = 1;
    step();
    set_idle();
    step(); step();
    chk("ign_hold", {31'd0, hold}, 32'd0);
    chk("ign_cnt", {24'd0, exc_count}, 32'd0);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      insn_done = ($urandom_range(0, 2) == 0);
      intreq    = ($urandom_range(0, 3) == 0);
      eret      = ($urandom_range(0, 7) == 0);
      syscall   = ($urandom_range(0, 7) == 0);
      next_pc   = 30'($urandom);
      epc       = 30'($urandom);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; set_idle();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception/interrupt entry-and-return sequencer for the multi-cycle MIPS core. It sits between the control unit and the CP0 register block. At each instruction boundary it decides whether to take an interrupt, a SYSCALL, or an ERET. It then drives CP0's `epc_we`/`exlset`/`exlclr` strobes and the PC-load path in a fixed cycle sequence, stalling fetch while it does so.

## Interface
Parameters:
- `VECTOR` — default 30'h0000_1060 (byte address 32'h0000_4180 >> 2). Handler entry, word address [31:2].

Ports (clock and reset first):
- `clk` — in, 1. Single clock; all state changes on its rising edge.
- `rst` — in, 1. Reset is asynchronous and active-high.
- `intreq` — in, 1. Masked interrupt request from CP0 (already gated by IE/EXL).
- `insn_done` — in, 1. High for exactly the last cycle of each instruction.
- `eret` — in, 1. Decoded ERET, valid with `insn_done`.
- `syscall` — in, 1. Decoded SYSCALL, valid with `insn_done`.
- `next_pc` — in, 30. Word address of the next sequential instruction, valid with `insn_done`.
- `epc` — in, 30. Current EPC from CP0.
- `hold` — out, 1. Stalls fetch/PC update while sequencing.
- `epc_we` — out, 1. EPC write strobe to CP0.
- `pc_save` — out, 30. Value CP0 writes into EPC.
- `exlset` — out, 1. One-cycle pulse that sets SR.EXL.
- `exlclr` — out, 1. One-cycle pulse that clears SR.EXL.
- `pc_load` — out, 1. Forces the PC to `pc_target`.
- `pc_target` — out, 30. Handler vector or EPC.
- `exc_code` — out, 5. Cause of the last entry: 0 = Int, 8 = Sys.
- `exc_count` — out, 8. Number of entries taken; wraps modulo 256.

## Operation
- Four states: IDLE, SAVE, ENTER, RET. All outputs are registered (Moore), so CP0's async `exlset`/`exlclr` inputs never see glitches.
- Decisions are made only in IDLE, on a cycle with `insn_done`=1. Priority is `eret` > `syscall` > `intreq`.
  - `eret`: go to RET.
  - `syscall` or `intreq`: latch `next_pc` into `pc_save`, latch `exc_code` (8 or 0), go to SAVE.
  - None of the above: stay in IDLE.
- SAVE: `epc_we`=1, `hold`=1; next state is ENTER.
- ENTER: `exlset`=1, `pc_load`=1, `pc_target`=`VECTOR`, `hold`=1; `exc_count` increments; next state is IDLE.
- RET: `exlclr`=1, `pc_load`=1, `pc_target`=`epc` (sampled on entry to RET), `hold`=1; next state is IDLE.
- Outside IDLE, `insn_done`, `eret`, `syscall` and `intreq` are ignored; `hold` guarantees no new boundary occurs.
- `intreq` is level-sampled, not latched. If it drops before a boundary, no interrupt is taken.
- After RET, a still-asserted `intreq` is taken at the next `insn_done`. That boundary is the first instruction after ERET, which retires normally.
- `pc_save` and `exc_code` hold their values until the next entry.

## Timing
- Let T be the boundary cycle where an entry is decided.
  - `epc_we` is high in T+1.
  - `exlset`/`pc_load` are high in T+2.
  - The first handler fetch happens in T+3.
  - Entry latency is 2 cycles of `hold`.
- ERET decided at T: `exlclr`/`pc_load` are high in T+1; resumed fetch at T+2.
- Each strobe is exactly one cycle wide. `epc_we` and `exlset` are never high in the same cycle.
- Reset values: state IDLE; `hold`, `epc_we`, `exlset`, `exlclr`, `pc_load` = 0; `pc_save`, `pc_target` = 0; `exc_code` = 0; `exc_count` = 0.
- Reset asserted mid-sequence (SAVE, ENTER or RET): all strobes drop immediately (asynchronous) and the state returns to IDLE. No partial EXL set is ever issued after reset.

## Configuration
- `EXC_SYSCALL_EN`:
  - Defined: `syscall` is decoded as above with code 8.
  - Undefined: the `syscall` port remains but is ignored, only `eret` and `intreq` are arbitrated, and `exc_code` is always 0.

## Test plan
- Interrupt entry: after reset, `intreq`=1 with `insn_done`=1, `next_pc`=30'h100 → `epc_we` at T+1 with `pc_save`=30'h100; `exlset`+`pc_load` at T+2 with `pc_target`=30'h1060; `exc_count`=1, `exc_code`=0.
- ERET: `epc`=30'h100, `eret`+`insn_done` → `exlclr`+`pc_load` at T+1, `pc_target`=30'h100; `hold` high for exactly 1 cycle.
- Priority: `eret`, `syscall` and `intreq` all high at one boundary → RET path taken; `epc_we` never asserted.
- Syscall (macro defined): `syscall`+`insn_done`, `next_pc`=30'h204 → `pc_save`=30'h204, `exc_code`=8. With the macro undefined → no entry, `hold` stays 0.
- Reset mid-sequence: `rst` asserted during SAVE → `epc_we` drops the same cycle; `exlset` never pulses; state is IDLE after release.
- Wrap and ignore: 256 interrupt entries → `exc_count` returns to 0. `intreq` pulsed only while `hold`=1 → no extra entry.
